// File: rtl/tpu_pkg.sv
// Shared types and default sizing for the instruction-fetch prefetcher.
package tpu_pkg;
  localparam int INS_W_DEF    = 64;
  localparam int ADDR_W_DEF   = 12;
  localparam int PF_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WFI   = 2'd2
  } ifu_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; push while full is accepted when a pop frees a slot.
module sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          full, do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_q];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: streams sequential reads from a 1-cycle imem into a small
// queue for the decoder, with start/redirect/WFI flushes.
module ifu_prefetch
  import tpu_pkg::*;
#(
  parameter int INS_W    = INS_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PF_DEPTH = PF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_vld,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              redir_vld,
  input  logic [ADDR_W-1:0] redir_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INS_W-1:0]  imem_rdata,
  input  logic              idu_ifu_rdy,
  input  logic              idu_ifu_wfi,
  output logic              ifu_idu_vld,
  output logic [INS_W-1:0]  ifu_idu_ins,
  output logic [ADDR_W-1:0] ifu_idu_pc,
  output logic              ifu_busy
);
  localparam int EW = INS_W + ADDR_W;
  localparam int CW = ((PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(PF_DEPTH);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, infl_pc_q;
  logic              ep_q, ep_d, infl_q, infl_ep_q;
  logic              flush, req, push, pop, q_empty;
  logic [CW-1:0]     q_cnt;
  logic [CW:0]       occ;
  logic [EW-1:0]     q_head;

  // Each issued read is counted against the queue until it lands or is flushed.
  assign occ = {1'b0, q_cnt} + {{CW{1'b0}}, infl_q};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    req     = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (start_vld) begin
          pc_d  = start_addr;
          flush = 1'b1;
        end else if (idu_ifu_wfi) begin
          state_d = ST_WFI;
          flush   = 1'b1;
        end else if (redir_vld) begin
          pc_d  = redir_addr;
          flush = 1'b1;
        end else if (occ < DEPTH_L) begin
          req  = 1'b1;
          pc_d = pc_q + 1'b1;
        end
      end
      default: begin
        if (start_vld) begin
          state_d = ST_FETCH;
          pc_d    = start_addr;
          flush   = 1'b1;
        end
      end
    endcase
    ep_d = flush ? ~ep_q : ep_q;
    if (rst) req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ep_q      <= 1'b0;
      infl_q    <= 1'b0;
      infl_ep_q <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ep_q      <= ep_d;
      infl_q    <= req;
      infl_ep_q <= ep_q;
      infl_pc_q <= pc_q;
    end
  end

  // A response landing in a flush cycle belongs to the old stream and is dropped.
  assign push = infl_q && (infl_ep_q == ep_q) && !flush;
  assign pop  = ifu_idu_vld && idu_ifu_rdy;

  sync_fifo #(.W(EW), .DEPTH(PF_DEPTH)) u_q (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .wdata ({infl_pc_q, imem_rdata}),
    .pop   (pop),
    .rdata (q_head),
    .empty (q_empty),
    .count (q_cnt)
  );

  assign ifu_idu_vld = !q_empty;
  assign ifu_idu_ins = ifu_idu_vld ? q_head[INS_W-1:0] : '0;
  assign ifu_idu_pc  = ifu_idu_vld ? q_head[EW-1:INS_W] : '0;
  assign imem_req    = req;
  assign imem_addr   = pc_q;
  assign ifu_busy    = (state_q == ST_FETCH);
endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized scoreboard bench for ifu_prefetch against a stream-level fetch model.
module tb_ifu_prefetch;
  localparam int INS_W = 64, ADDR_W = 12, DEPTH = 4;

  logic              clk, rst;
  logic              start_vld, redir_vld, idu_ifu_rdy, idu_ifu_wfi;
  logic [ADDR_W-1:0] start_addr, redir_addr, imem_addr, ifu_idu_pc;
  logic              imem_req, ifu_idu_vld, ifu_busy;
  logic [INS_W-1:0]  imem_rdata, ifu_idu_ins;

  ifu_prefetch #(.INS_W(INS_W), .ADDR_W(ADDR_W), .PF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start_vld(start_vld), .start_addr(start_addr),
    .redir_vld(redir_vld), .redir_addr(redir_addr), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .idu_ifu_rdy(idu_ifu_rdy),
    .idu_ifu_wfi(idu_ifu_wfi), .ifu_idu_vld(ifu_idu_vld), .ifu_idu_ins(ifu_idu_ins),
    .ifu_idu_pc(ifu_idu_pc), .ifu_busy(ifu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(logic [11:0] a);
    logic [31:0] lo;
    lo = 32'(a) * 32'h9E3779B1;
    return {20'hC0DE0, a, lo};
  endfunction

  typedef struct { logic [11:0] pc; logic [63:0] ins; int vis; } exp_t;
  exp_t        sb[$];
  int          checks = 0, errors = 0, cyc = 0;
  int          m_state = 0;   // 0 idle, 1 fetching, 2 waiting-for-interrupt
  logic [11:0] m_pc = '0;
  bit          after_rst = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Memory model: answers one cycle after each sampled request, garbage otherwise.
  logic        mr_q = 1'b0;
  logic [11:0] ma_q = '0;
  always @(negedge clk) begin
    mr_q = imem_req;
    ma_q = imem_addr;
  end
  always @(posedge clk) begin
    #1;
    imem_rdata = mr_q ? mem_word(ma_q) : {$urandom, $urandom};
  end

  // Monitor / scoreboard: every issued fetch expects its word back in order, visible 2 cycles later.
  always @(negedge clk) begin
    bit ev, exp_req, exp_vld;
    if (rst) begin
      sb.delete();
      m_state   = 0;
      m_pc      = '0;
      after_rst = 1;
    end else begin
      if (after_rst) begin
        chk("rst_addr", 64'(imem_addr), 64'd0);
        chk("rst_ins", ifu_idu_ins, 64'd0);
        chk("rst_pc", 64'(ifu_idu_pc), 64'd0);
        after_rst = 0;
      end
      ev      = start_vld || (m_state == 1 && (redir_vld || idu_ifu_wfi));
      exp_req = (m_state == 1) && !ev && (sb.size() < DEPTH);
      exp_vld = (sb.size() > 0) && (sb[0].vis <= cyc);
      chk("busy", 64'(ifu_busy), 64'(m_state == 1));
      chk("req", 64'(imem_req), 64'(exp_req));
      chk("vld", 64'(ifu_idu_vld), 64'(exp_vld));
      if (exp_vld && ifu_idu_vld) begin
        chk("pc", 64'(ifu_idu_pc), 64'(sb[0].pc));
        chk("ins", ifu_idu_ins, sb[0].ins);
        if (idu_ifu_rdy) void'(sb.pop_front());
      end
      if (exp_req && imem_req) begin
        chk("addr", 64'(imem_addr), 64'(m_pc));
        sb.push_back('{m_pc, mem_word(m_pc), cyc + 2});
        m_pc = m_pc + 1'b1;
      end
      if (start_vld) begin
        sb.delete(); m_pc = start_addr; m_state = 1;
      end else if (m_state == 1 && idu_ifu_wfi) begin
        sb.delete(); m_state = 2;
      end else if (m_state == 1 && redir_vld) begin
        sb.delete(); m_pc = redir_addr;
      end
    end
    cyc++;
  end

  task automatic drive(bit s, logic [11:0] sa, bit r, logic [11:0] ra, bit w, bit rd, bit rs);
    @(posedge clk);
    #1;
    start_vld = s; start_addr = sa; redir_vld = r; redir_addr = ra;
    idu_ifu_wfi = w; idu_ifu_rdy = rd; rst = rs;
  endtask

  task automatic idle(int n, bit rd);
    repeat (n) drive(0, '0, 0, '0, 0, rd, 0);
  endtask

  initial begin
    rst = 1'b1; start_vld = 0; start_addr = '0; redir_vld = 0; redir_addr = '0;
    idu_ifu_wfi = 0; idu_ifu_rdy = 0;
    drive(0, '0, 0, '0, 0, 0, 1);
    drive(0, '0, 0, '0, 0, 0, 1);
    idle(3, 1);
    drive(1, 12'h010, 0, '0, 0, 1, 0); idle(20, 1);
    idle(12, 0); idle(10, 1);
    drive(1, 12'hFFE, 0, '0, 0, 1, 0); idle(8, 1);
    drive(1, 12'h200, 0, '0, 0, 0, 0); idle(4, 0);
    drive(0, '0, 1, 12'h100, 0, 0, 0); idle(6, 0); idle(6, 1);
    drive(0, '0, 0, '0, 1, 1, 0); idle(3, 1);
    drive(0, '0, 1, 12'h300, 0, 1, 0); idle(3, 1);
    drive(1, 12'h040, 0, '0, 0, 1, 0); idle(5, 1);
    drive(1, 12'h050, 0, '0, 1, 1, 0); idle(8, 1);
    drive(0, '0, 0, '0, 0, 1, 1); idle(4, 1);
    drive(1, 12'h060, 0, '0, 0, 0, 0); idle(5, 0);
    drive(0, '0, 0, '0, 0, 0, 1); idle(3, 1);
    drive(1, 12'h070, 1, 12'h700, 0, 1, 0); idle(6, 1);
    repeat (1500) begin
      drive(($urandom % 50) == 0, 12'($urandom), ($urandom % 30) == 0, 12'($urandom),
            ($urandom % 60) == 0, ($urandom % 10) < 7, ($urandom % 300) == 0);
    end
    idle(10, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
